wr_ptr_gen: RTL and testbench
=============================

WR_PTR_GEN -- requirements
Module: wr_ptr_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: FIFO address width; depth DEPTH = 2^ADDR_WIDTH; legal range 2..12.
REQ-002 SHALL have parameter AFULL_THRESH, default 2: almost_full asserts when free slots <= AFULL_THRESH; legal range 1..DEPTH-1.
REQ-003 SHALL have port wr_clk  in  1  write-domain clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port write_en  in  1  write request.
REQ-006 SHALL have port rd_ptr_gray_sync  in  ADDR_WIDTH+1  read pointer (Gray), already synchronised into wr_clk.
REQ-007 SHALL have port ovf_clear  in  1  clears sticky overflow.
REQ-008 SHALL have port wr_accept  out  1  combinational: write_en & ~full.
REQ-009 SHALL have port wr_addr  out  ADDR_WIDTH  RAM write address = wr_ptr_bin[ADDR_WIDTH-1:0].
REQ-010 SHALL have port wr_ptr_bin  out  ADDR_WIDTH+1  registered binary pointer, wrap bit at MSB.
REQ-011 SHALL have port wr_ptr_gray  out  ADDR_WIDTH+1  registered Gray pointer for crossing to the read domain.
REQ-012 SHALL have port full  out  1  registered full flag.
REQ-013 SHALL have port almost_full  out  1  registered almost-full flag.
REQ-014 SHALL have port wr_level  out  ADDR_WIDTH+1  registered occupancy, 0..DEPTH.
REQ-015 SHALL have port overflow  out  1  sticky: a write was attempted while full.

Function
REQ-016 On wr_accept, bin_next SHALL be wr_ptr_bin+1 modulo 2^(ADDR_WIDTH+1); otherwise bin_next = wr_ptr_bin.
REQ-017 wr_ptr_gray SHALL be registered from bin_next ^ (bin_next>>1) in the same edge as wr_ptr_bin; the two are never out of step.
REQ-018 The Gray pointer SHALL change by exactly one bit per accepted write, including at wrap-around from 2^(ADDR_WIDTH+1)-1 to 0.
REQ-019 rd_bin SHALL be the combinational Gray-to-binary conversion of rd_ptr_gray_sync.
REQ-020 level_next SHALL be (bin_next - rd_bin) modulo 2^(ADDR_WIDTH+1); wr_level is registered from level_next.
REQ-021 full SHALL be registered from (gray_next == {~rd_ptr_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1], rd_ptr_gray_sync[ADDR_WIDTH-2:0]}); full asserts on the edge that accepts the DEPTH-th outstanding write.
REQ-022 almost_full SHALL be registered from level_next >= DEPTH-AFULL_THRESH.
REQ-023 full, almost_full and wr_level SHALL deassert/decrease only through rd_ptr_gray_sync advancing; latency is one wr_clk after rd_ptr_gray_sync changes.
REQ-024 write_en while full SHALL be rejected: pointers hold, wr_accept=0.
REQ-025 Simultaneous accepted write and read-pointer advance SHALL leave wr_level unchanged and full unchanged.
REQ-026 A write_en while full SHALL set overflow on the next edge; ovf_clear clears it; set wins when both occur in the same cycle.

Reset
REQ-027 While rst=1 at a wr_clk edge, wr_ptr_bin, wr_ptr_gray, wr_level, full, almost_full and overflow SHALL all become 0, overriding write_en and ovf_clear.
REQ-028 Reset asserted mid-stream SHALL discard pointer state; the first accepted write after release goes to wr_addr 0.

Configuration
REQ-029 Macro WR_PTR_OVERFLOW_EN: when defined, overflow logic per REQ-026 is built; when undefined, the overflow port SHALL remain present, tied to 0, and ovf_clear is ignored.

Verification
REQ-030 Defaults: reset, then 16 consecutive write_en with rd_ptr_gray_sync=0 -> full=1 after the 16th edge, wr_level=16, wr_ptr_bin=5'h10, almost_full=1 from wr_level=14.
REQ-031 Full, write_en=1 for 3 cycles -> wr_ptr_bin holds 5'h10, wr_accept=0, overflow=1 (WR_PTR_OVERFLOW_EN defined) or 0 (undefined).
REQ-032 Full, rd_ptr_gray_sync set to Gray(1)=5'h01 -> full=0 and wr_level=15 one edge later.
REQ-033 Drive 40 writes with read keeping pace -> wr_ptr_bin wraps 31->0, wr_ptr_gray has Hamming distance 1 on every change, wr_addr cycles 0..15.
REQ-034 Assert rst for one edge at wr_ptr_bin=7 with write_en=1 -> all outputs 0 next cycle, next accepted write at wr_addr 0.
REQ-035 overflow=1, ovf_clear=1 and write_en=1 while full in the same cycle -> overflow remains 1.

Source files
------------

// File: rtl/wr_ptr_gen.sv
// wr_ptr_gen -- write-side pointer and flag generator for an async FIFO.
//
// Keeps the binary and Gray write pointers in lock-step, derives occupancy
// against the read pointer that has already been synchronised into wr_clk,
// and produces registered full / almost_full / level flags.
//
// Parameters
//   ADDR_WIDTH   : FIFO address width, DEPTH = 2**ADDR_WIDTH (2..12)
//   AFULL_THRESH : almost_full when free slots <= AFULL_THRESH (1..DEPTH-1)
//
// Ports
//   wr_clk           in   write-domain clock (rising edge)
//   rst              in   synchronous active-high reset
//   write_en         in   write request
//   rd_ptr_gray_sync in   Gray read pointer, already in wr_clk domain
//   ovf_clear        in   clears sticky overflow
//   wr_accept        out  write_en & ~full (combinational)
//   wr_addr          out  RAM write address (pointer LSBs)
//   wr_ptr_bin       out  registered binary pointer, wrap bit at MSB
//   wr_ptr_gray      out  registered Gray pointer for the read domain
//   full             out  registered full flag
//   almost_full      out  registered almost-full flag
//   wr_level         out  registered occupancy 0..DEPTH
//   overflow         out  sticky: write attempted while full
//
// Build option
//   WR_PTR_OVERFLOW_EN : when defined, the sticky overflow flag is built;
//                        otherwise overflow is tied low and ovf_clear ignored.

module wr_ptr_gen #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 2
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
  input  logic                  ovf_clear,
  output logic                  wr_accept,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_bin,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] AFULL_LVL = PW'(DEPTH - AFULL_THRESH);

  logic [PW-1:0] bin_next, gray_next, rd_bin, level_next, full_cmp;
  logic          full_next, afull_next;

  assign wr_accept = write_en & ~full;
  assign wr_addr   = wr_ptr_bin[ADDR_WIDTH-1:0];

  // Pointer increments modulo 2**PW; the MSB is the wrap bit.
  assign bin_next  = wr_ptr_bin + PW'(wr_accept);
  assign gray_next = bin_next ^ (bin_next >> 1);

  // Gray -> binary: each bit is the XOR of all Gray bits at or above it.
  assign rd_bin[PW-1] = rd_ptr_gray_sync[PW-1];
  genvar i;
  generate
    for (i = PW-2; i >= 0; i--) begin : g_g2b
      assign rd_bin[i] = rd_bin[i+1] ^ rd_ptr_gray_sync[i];
    end
  endgenerate

  assign level_next = bin_next - rd_bin;

  // In Gray code, "write is exactly one lap ahead" means the top two bits
  // are inverted and the rest match.
  assign full_cmp   = {~rd_ptr_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                       rd_ptr_gray_sync[ADDR_WIDTH-2:0]};
  assign full_next  = (gray_next == full_cmp);
  assign afull_next = (level_next >= AFULL_LVL);

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      wr_ptr_bin  <= '0;
      wr_ptr_gray <= '0;
      wr_level    <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      wr_ptr_bin  <= bin_next;
      wr_ptr_gray <= gray_next;
      wr_level    <= level_next;
      full        <= full_next;
      almost_full <= afull_next;
    end
  end

`ifdef WR_PTR_OVERFLOW_EN
  // Set has priority over clear so an overflow in the clearing cycle is kept.
  always_ff @(posedge wr_clk) begin
    if (rst)                   overflow <= 1'b0;
    else if (write_en & full)  overflow <= 1'b1;
    else if (ovf_clear)        overflow <= 1'b0;
  end
`else
  logic unused_ovf_clear;
  assign unused_ovf_clear = ovf_clear;
  assign overflow         = 1'b0;
`endif

endmodule

// File: tb/tb_wr_ptr_gen.sv
module tb_wr_ptr_gen;
  localparam int AW = 4;
  localparam int DEPTH = 16;
`ifdef WR_PTR_OVERFLOW_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic wr_clk = 1'b0;
  logic rst = 1'b0, write_en = 1'b0, ovf_clear = 1'b0;
  logic [AW:0] rd_ptr_gray_sync = '0;
  logic wr_accept, full, almost_full, overflow;
  logic [AW-1:0] wr_addr;
  logic [AW:0] wr_ptr_bin, wr_ptr_gray, wr_level;

  always #5 wr_clk = ~wr_clk;

  wr_ptr_gen dut (
    .wr_clk(wr_clk), .rst(rst), .write_en(write_en),
    .rd_ptr_gray_sync(rd_ptr_gray_sync), .ovf_clear(ovf_clear),
    .wr_accept(wr_accept), .wr_addr(wr_addr), .wr_ptr_bin(wr_ptr_bin),
    .wr_ptr_gray(wr_ptr_gray), .full(full), .almost_full(almost_full),
    .wr_level(wr_level), .overflow(overflow)
  );

  int n_chk = 0, n_fail = 0;

  // Reference model: counts of writes done and reads done; everything else
  // follows arithmetically from those counts.
  int m_wr = 0;
  int m_rd = 0;
  bit m_full = 0, m_af = 0, m_ovf = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW:0] to_gray(input int n);
    logic [AW:0] b;
    b = (AW+1)'(n);
    return b ^ (b >> 1);
  endfunction

  // One clock: drive inputs just after a rising edge, check combinational
  // accept, advance the model, then check registered outputs after the edge.
  task automatic apply(input bit r, input bit we, input int rdn, input bit clr);
    bit acc;
    int lvl;
    rst = r; write_en = we; ovf_clear = clr;
    rd_ptr_gray_sync = to_gray(rdn);
    #1;
    acc = we && !m_full;
    chk("wr_accept", int'(wr_accept), int'(acc));
    chk("wr_addr", int'(wr_addr), m_wr % DEPTH);
    if (r) begin
      m_wr = 0; m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      if (OVF) begin
        if (we && m_full) m_ovf = 1;
        else if (clr)     m_ovf = 0;
      end
      if (acc) m_wr++;
      m_rd = rdn;
      lvl = m_wr - m_rd;
      m_full = (lvl == DEPTH);
      m_af = (lvl >= DEPTH - 2);
    end
    @(posedge wr_clk); #1;
    chk("wr_ptr_bin", int'(wr_ptr_bin), m_wr % (2*DEPTH));
    chk("wr_ptr_gray", int'(wr_ptr_gray), int'(to_gray(m_wr % (2*DEPTH))));
    chk("wr_level", int'(wr_level), r ? 0 : m_wr - m_rd);
    chk("full", int'(full), int'(m_full));
    chk("almost_full", int'(almost_full), int'(m_af));
    chk("overflow", int'(overflow), int'(m_ovf));
  endtask

  typedef struct {
    bit r, we, clr;
    int rd;
    int e_bin, e_lvl;
    bit e_full, e_af, e_acc, e_ovf;
  } vec_t;
  vec_t tbl[24];

  function automatic vec_t mk(bit r, bit we, int rd, bit clr, int eb, int el,
                              bit ef, bit ea, bit eacc, bit eo);
    vec_t v;
    v.r = r; v.we = we; v.rd = rd; v.clr = clr; v.e_bin = eb; v.e_lvl = el;
    v.e_full = ef; v.e_af = ea; v.e_acc = eacc; v.e_ovf = eo;
    return v;
  endfunction

  initial begin
    logic [AW:0] pg;
    bit wrapped;
    int rdn;

    // Fill: reset, 16 writes to full, 3 rejected writes, one read,
    // refill, clear-vs-set collision, then a plain clear.
    tbl[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 16; i++)
      tbl[i] = mk(0, 1, 0, 0, i, i, i == 16, i >= 14, 1, 0);
    for (int i = 17; i <= 19; i++)
      tbl[i] = mk(0, 1, 0, 0, 16, 16, 1, 1, 0, OVF);
    tbl[20] = mk(0, 0, 1, 0, 16, 15, 0, 1, 0, OVF);
    tbl[21] = mk(0, 1, 1, 0, 17, 16, 1, 1, 1, OVF);
    tbl[22] = mk(0, 1, 1, 1, 17, 16, 1, 1, 0, OVF);
    tbl[23] = mk(0, 0, 1, 1, 17, 16, 1, 1, 0, 0);

    @(posedge wr_clk); #1;
    for (int i = 0; i < 24; i++) begin
      rst = tbl[i].r; write_en = tbl[i].we; ovf_clear = tbl[i].clr;
      rd_ptr_gray_sync = to_gray(tbl[i].rd);
      #1;
      chk("tbl_accept", int'(wr_accept), int'(tbl[i].e_acc));
      apply(tbl[i].r, tbl[i].we, tbl[i].rd, tbl[i].clr);
      chk("tbl_bin", int'(wr_ptr_bin), tbl[i].e_bin);
      chk("tbl_level", int'(wr_level), tbl[i].e_lvl);
      chk("tbl_full", int'(full), int'(tbl[i].e_full));
      chk("tbl_afull", int'(almost_full), int'(tbl[i].e_af));
      chk("tbl_ovf", int'(overflow), int'(tbl[i].e_ovf));
    end

    // Mid-stream reset at wr_ptr_bin=7 with a write pending.
    apply(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) apply(0, 1, i, 0);
    chk("pre_rst_bin", int'(wr_ptr_bin), 7);
    apply(1, 1, 7, 0);
    chk("rst_bin", int'(wr_ptr_bin), 0);
    chk("rst_level", int'(wr_level), 0);
    chk("rst_gray", int'(wr_ptr_gray), 0);
    write_en = 1; rst = 0; rd_ptr_gray_sync = '0; #1;
    chk("post_rst_addr", int'(wr_addr), 0);
    apply(0, 1, 0, 0);
    chk("post_rst_bin", int'(wr_ptr_bin), 1);

    // 40 writes with reads keeping pace: wrap and one-bit Gray steps.
    apply(1, 0, 0, 0);
    pg = wr_ptr_gray; wrapped = 0;
    for (int i = 0; i < 40; i++) begin
      apply(0, 1, (i > 0) ? i - 1 : 0, 0);
      chk("gray_hamming", $countones(pg ^ wr_ptr_gray), 1);
      if (pg == 5'h10 && wr_ptr_gray == 5'h00) wrapped = 1;
      pg = wr_ptr_gray;
    end
    chk("wrap_seen", int'(wrapped), 1);

    // Randomised traffic against the count-based model.
    apply(1, 0, 0, 0);
    rdn = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r, we, clr;
      r = ($urandom_range(199) == 0);
      we = ($urandom_range(99) < 60);
      clr = ($urandom_range(9) == 0);
      if (rdn < m_wr && $urandom_range(99) < 45) rdn++;
      apply(r, we, rdn, clr);
      if (r) rdn = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
